wb_mul_master: RTL and testbench

- Wishbone classic-cycle initiator that drives the approximate-multiplier Wishbone responder from a simple command interface.
- On a start pulse it performs three single transfers: write operand A, write operand B, read the product. It returns the product with a done pulse.
- Sits between the logic-analyzer or test control logic and the multiplier's wbs_* port, so the multiplier can be exercised without the management SoC.

---
 rtl/wb_mul_master.sv | 153 +++++++++++++++
 tb/tb_wb_mul_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_mul_master.sv
// Wishbone classic-cycle initiator for the approximate multiplier.
// A start pulse writes operand A, writes operand B, reads the product
// back and reports completion with a one-cycle done pulse.
module wb_mul_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] A_OFF     = 32'h0,
  parameter logic [31:0] B_OFF     = 32'h4,
  parameter logic [31:0] RES_OFF   = 32'h8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [15:0] op_a_i,
  input  logic [15:0] op_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] result_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [31:0] ADR_A   = BASE_ADDR + A_OFF;
  localparam logic [31:0] ADR_B   = BASE_ADDR + B_OFF;
  localparam logic [31:0] ADR_RES = BASE_ADDR + RES_OFF;
  // Last wait-cycle count before the transfer is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_GAP_A, S_WR_B, S_GAP_B, S_RD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  state_t      nxt;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] res_q, res_d;
  logic        xfer;

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic and bus outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    res_d     = res_q;
    nxt       = state_q;
    xfer      = 1'b0;
    done_o    = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = 32'h0;
    wbm_dat_o = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = op_a_i;
          b_d     = op_b_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_WR_A;
        end
      end
      S_WR_A: begin
        xfer      = 1'b1;
        nxt       = S_GAP_A;
        wbm_we_o  = 1'b1;
        wbm_adr_o = ADR_A;
        wbm_dat_o = {16'h0, a_q};
      end
      S_GAP_A: begin
        cnt_d   = '0;
        state_d = S_WR_B;
      end
      S_WR_B: begin
        xfer      = 1'b1;
        nxt       = S_GAP_B;
        wbm_we_o  = 1'b1;
        wbm_adr_o = ADR_B;
        wbm_dat_o = {16'h0, b_q};
      end
      S_GAP_B: begin
        cnt_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        xfer      = 1'b1;
        nxt       = S_DONE;
        wbm_adr_o = ADR_RES;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared transfer handshake: ack beats the timeout in the same cycle.
    if (xfer) begin
      wbm_cyc_o = 1'b1;
      wbm_stb_o = 1'b1;
      wbm_sel_o = 4'hF;
      if (wbm_ack_i) begin
        state_d = nxt;
        cnt_d   = '0;
        if (state_q == S_RD) res_d = wbm_dat_i;
      end else if (cnt_q == TO_LAST) begin
        state_d = S_DONE;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign busy_o   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err_o    = err_q;
  assign result_o = res_q;

endmodule

// File: tb/tb_wb_mul_master.sv
// Directed bench for wb_mul_master with a small multiplier slave model.
module tb_wb_mul_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        busy, done, err;
  logic [31:0] result;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;

  wb_mul_master #(.TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
    .op_a_i(op_a), .op_b_i(op_b),
    .busy_o(busy), .done_o(done), .err_o(err), .result_o(result),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  initial forever #5 clk = ~clk;

  // Slave model: mode 0 zero-wait, 1 one-wait, 2 one-wait but never acks B.
  int          mode = 1;
  logic        ack_q;
  logic [31:0] ra = '0, rb = '0;
  assign ack = (mode == 0) ? (cyc & stb) :
               (mode == 1) ? ack_q : (ack_q && adr != 32'h3000_0004);
  assign dat_i = 32'(ra[15:0]) * 32'(rb[15:0]);

  always @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= cyc & stb & ~ack_q;
  end

  logic [64:0] log_q[$];
  always @(posedge clk) begin
    if (!rst && cyc && stb && ack) begin
      log_q.push_back({we, adr, dat_o});
      if (we && adr == 32'h3000_0000) ra <= dat_o;
      if (we && adr == 32'h3000_0004) rb <= dat_o;
    end
  end

  int   vectors = 0, errors = 0;
  int   done_cyc, ndone, sel_bad;
  logic stb_hist[0:63];
  logic busy_hist[0:63];
  logic err_hist[0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {25'd0, busy, done, err, cyc, stb, we, sel}, 32'h0);
    chk({tag, "_res"}, result, 32'h0);
    chk({tag, "_adr"}, adr, 32'h0);
    chk({tag, "_dat"}, dat_o, 32'h0);
  endtask

  // Starts a transaction at the current negedge; cycle c is sampled at the
  // negedge following edge E(c-1). kind 1 injects a second start, kind 2 a reset.
  task automatic txn(input logic [15:0] a, input logic [15:0] b, input int inj_c,
                     input int kind, input int ncyc, input bit stop);
    log_q.delete();
    done_cyc = -1; ndone = 0; sel_bad = 0;
    op_a = a; op_b = b; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      stb_hist[c] = stb; busy_hist[c] = busy; err_hist[c] = err;
      if (stb && sel != 4'hF) sel_bad++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (kind == 1 && c == inj_c) begin start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; end
      if (kind == 1 && c == inj_c + 1) start = 1'b0;
      if (kind == 2 && c == inj_c) begin chk("rst_pre_stb", {31'd0, stb}, 32'h1); rst = 1'b1; end
      if (kind == 2 && c == inj_c + 1) begin chk_idle("rst_mid"); rst = 1'b0; end
      if (stop && done) break;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // Basic transaction with a one-wait slave.
    mode = 1;
    txn(16'h0012, 16'h0034, 0, 0, 40, 1'b1);
    chk("basic_done_cyc", done_cyc, 32'd9);
    chk("basic_result", result, 32'h0000_03A8);
    chk("basic_err", {31'd0, err}, 32'h0);
    chk("basic_busy_c1", {31'd0, busy_hist[1]}, 32'h1);
    chk("basic_nxfer", log_q.size(), 32'd3);
    chk("basic_wa_adr", log_q[0][63:32], 32'h3000_0000);
    chk("basic_wa_dat", log_q[0][31:0], 32'h0000_0012);
    chk("basic_wa_we", {31'd0, log_q[0][64]}, 32'h1);
    chk("basic_wb_adr", log_q[1][63:32], 32'h3000_0004);
    chk("basic_wb_dat", log_q[1][31:0], 32'h0000_0034);
    chk("basic_rd_adr", log_q[2][63:32], 32'h3000_0008);
    chk("basic_rd_we", {31'd0, log_q[2][64]}, 32'h0);
    chk("basic_gap_a", {31'd0, stb_hist[3]}, 32'h0);
    @(negedge clk);
    chk("basic_c10", {30'd0, done, busy}, 32'h0);

    // Zero-wait slave.
    mode = 0;
    txn(16'h0012, 16'h0034, 0, 0, 40, 1'b1);
    chk("zw_done_cyc", done_cyc, 32'd6);
    chk("zw_stb_pat", {27'd0, stb_hist[1], stb_hist[2], stb_hist[3], stb_hist[4], stb_hist[5]}, 32'b10101);
    chk("zw_sel", sel_bad, 32'd0);
    chk("zw_result", result, 32'h0000_03A8);
    @(negedge clk);

    // Timeout on WR_B.
    mode = 2;
    txn(16'h0005, 16'h0007, 0, 0, 40, 1'b0);
    chk("to_ndone", ndone, 32'd1);
    chk("to_done_cyc", done_cyc, 32'd12);
    chk("to_stb_c11", {31'd0, stb_hist[11]}, 32'h1);
    chk("to_stb_c12", {31'd0, stb_hist[12]}, 32'h0);
    chk("to_nxfer", log_q.size(), 32'd1);
    chk("to_err", {31'd0, err}, 32'h1);
    chk("to_result", result, 32'h0000_03A8);

    // Next start clears the sticky error.
    mode = 1;
    txn(16'h0003, 16'h0005, 0, 0, 40, 1'b1);
    chk("clr_err_c1", {31'd0, err_hist[1]}, 32'h0);
    chk("clr_err_end", {31'd0, err}, 32'h0);
    chk("clr_result", result, 32'h0000_000F);
    @(negedge clk);

    // Start while busy is ignored.
    txn(16'h0100, 16'h0003, 4, 1, 25, 1'b0);
    chk("busy_ndone", ndone, 32'd1);
    chk("busy_result", result, 32'h0000_0300);
    chk("busy_wa_dat", log_q[0][31:0], 32'h0000_0100);
    chk("busy_nxfer", log_q.size(), 32'd3);

    // Reset in the first RD cycle.
    txn(16'h0002, 16'h0003, 7, 2, 25, 1'b0);
    chk("rst_ndone", ndone, 32'd0);
    txn(16'h0012, 16'h0034, 0, 0, 40, 1'b1);
    chk("rst_fresh_done", done_cyc, 32'd9);
    chk("rst_fresh_res", result, 32'h0000_03A8);

    // Back-to-back: second start in the cycle after done.
    @(negedge clk);
    txn(16'h0100, 16'h0010, 0, 0, 40, 1'b1);
    chk("b2b_done_cyc", done_cyc, 32'd9);
    chk("b2b_result", result, 32'h0000_1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
